// File: rtl/spi_xfer_pkg.sv
// Shared types for the SPI burst transfer controller: FSM state encoding and byte width.
package spi_xfer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        XFER,
        HOLD
    } xfer_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO; DEPTH must be a power of 2.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is refused even when a pop happens in the same cycle.
    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Burst controller in front of the SPI byte engine: CS setup/hold, per-byte start/done handshake, TX/RX FIFOs.
// Optional XFER watchdog enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl
    import spi_xfer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 8,
    parameter int CS_DLY     = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              go_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic [BYTE_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              cs_n_o,
    output logic [BYTE_W-1:0] spi_din_o,
    output logic              spi_start_o,
    input  logic              spi_ready_i,
    input  logic [BYTE_W-1:0] spi_dout_i,
    input  logic              spi_done_tick_i
);

    // cnt times CS setup/hold and doubles as the XFER watchdog, so it is sized for both.
    localparam int CNT_MAX = (CS_DLY > TIMEOUT) ? CS_DLY : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CS_LOAD = CNT_W'(CS_DLY - 1);

    xfer_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [LEN_W-1:0]  rem, rem_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              cs_n_q, cs_n_nxt;
    logic              start_q, start_nxt;
    logic [BYTE_W-1:0] din_q, din_nxt;
    logic              tx_pop, tx_full, tx_empty;
    logic [BYTE_W-1:0] tx_dout;
    logic              rx_push, rx_full, rx_empty;

    spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_valid_i),
        .data_i  (tx_data_i),
        .pop_i   (tx_pop),
        .data_o  (tx_dout),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_push),
        .data_i  (spi_dout_i),
        .pop_i   (rx_ready_i),
        .data_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

`ifdef SPI_XFER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    logic err_q, err_nxt;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rem_nxt   = rem;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        cs_n_nxt  = cs_n_q;
        start_nxt = 1'b0;
        din_nxt   = din_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
        err_nxt   = err_q;
`endif
        case (state)
            IDLE: begin
                if (go_i && (len_i != '0)) begin
                    rem_nxt   = len_i;
                    busy_nxt  = 1'b1;
                    cs_n_nxt  = 1'b0;
                    cnt_nxt   = CS_LOAD;
                    state_nxt = SETUP;
`ifdef SPI_XFER_TIMEOUT_EN
                    err_nxt   = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (cnt == '0) state_nxt = LOAD;
                else           cnt_nxt   = cnt - 1'b1;
            end
            LOAD: begin
                // Reserving an RX slot here means the push in XFER can never be refused.
                if (!tx_empty && !rx_full && spi_ready_i) begin
                    tx_pop    = 1'b1;
                    din_nxt   = tx_dout;
                    start_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (spi_done_tick_i) begin
                    rx_push = 1'b1;
                    rem_nxt = rem - 1'b1;
                    if (rem == LEN_W'(1)) begin
                        cnt_nxt   = CS_LOAD;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
`ifdef SPI_XFER_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = CS_LOAD;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (cnt == '0) begin
                    cs_n_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            start_q <= 1'b0;
            din_q   <= '0;
`ifdef SPI_XFER_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rem     <= rem_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            cs_n_q  <= cs_n_nxt;
            start_q <= start_nxt;
            din_q   <= din_nxt;
`ifdef SPI_XFER_TIMEOUT_EN
            err_q   <= err_nxt;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cs_n_o      = cs_n_q;
    assign spi_start_o = start_q;
    assign spi_din_o   = din_q;
    assign tx_ready_o  = !tx_full;
    assign rx_valid_o  = !rx_empty;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: two instances (FIFO depth 8 and 2) each driven by a simple SPI engine model.
module tb_spi_xfer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;
    int unsigned cyc = 0;
    int unsigned go_cyc = 0;
    logic go_cs_n;

    always @(posedge clk) cyc <= cyc + 1;

    // instance A: depth 8, CS_DLY 4, TIMEOUT 16
    logic [7:0] len, tx_data, rx_data, spi_din, spi_dout;
    logic go, busy, done, err, tx_valid, tx_ready, rx_valid, rx_ready;
    logic cs_n, spi_start, spi_ready, done_tick;

    spi_xfer_ctrl #(.FIFO_DEPTH(8), .LEN_W(8), .CS_DLY(4), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst_n), .len_i(len), .go_i(go), .busy_o(busy), .done_o(done),
        .err_o(err), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .cs_n_o(cs_n),
        .spi_din_o(spi_din), .spi_start_o(spi_start), .spi_ready_i(spi_ready),
        .spi_dout_i(spi_dout), .spi_done_tick_i(done_tick)
    );

    // instance B: depth 2 for RX backpressure
    logic [7:0] b_len, b_tx_data, b_rx_data, b_spi_din, b_spi_dout;
    logic b_go, b_busy, b_done, b_err, b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready;
    logic b_cs_n, b_spi_start, b_spi_ready, b_done_tick;

    spi_xfer_ctrl #(.FIFO_DEPTH(2), .LEN_W(8), .CS_DLY(4), .TIMEOUT(16)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .len_i(b_len), .go_i(b_go), .busy_o(b_busy), .done_o(b_done),
        .err_o(b_err), .tx_data_i(b_tx_data), .tx_valid_i(b_tx_valid), .tx_ready_o(b_tx_ready),
        .rx_data_o(b_rx_data), .rx_valid_o(b_rx_valid), .rx_ready_i(b_rx_ready), .cs_n_o(b_cs_n),
        .spi_din_o(b_spi_din), .spi_start_o(b_spi_start), .spi_ready_i(b_spi_ready),
        .spi_dout_i(b_spi_dout), .spi_done_tick_i(b_done_tick)
    );

    // Engine models: 3 cycles after start, return din ^ 8'h99 with a one-cycle done tick.
    logic       eng_busy, eng_hang, b_eng_busy;
    int         eng_cnt, b_eng_cnt;
    logic [7:0] eng_din, b_eng_din;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_busy <= 1'b0; eng_cnt <= 0; done_tick <= 1'b0; spi_dout <= 8'h00; eng_din <= 8'h00;
        end else begin
            done_tick <= 1'b0;
            if (eng_busy) begin
                if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
                else if (!eng_hang) begin
                    done_tick <= 1'b1; spi_dout <= eng_din ^ 8'h99; eng_busy <= 1'b0;
                end
            end else if (spi_start) begin
                eng_busy <= 1'b1; eng_cnt <= 2; eng_din <= spi_din;
            end
        end
    end
    assign spi_ready = !eng_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_eng_busy <= 1'b0; b_eng_cnt <= 0; b_done_tick <= 1'b0; b_spi_dout <= 8'h00; b_eng_din <= 8'h00;
        end else begin
            b_done_tick <= 1'b0;
            if (b_eng_busy) begin
                if (b_eng_cnt != 0) b_eng_cnt <= b_eng_cnt - 1;
                else begin
                    b_done_tick <= 1'b1; b_spi_dout <= b_eng_din ^ 8'h99; b_eng_busy <= 1'b0;
                end
            end else if (b_spi_start) begin
                b_eng_busy <= 1'b1; b_eng_cnt <= 2; b_eng_din <= b_spi_din;
            end
        end
    end
    assign b_spi_ready = !b_eng_busy;

    int n_start = 0, n_done = 0, n_glitch = 0, b_n_start = 0, b_n_done = 0;
    always @(posedge clk) begin
        if (spi_start)     n_start   <= n_start + 1;
        if (done)          n_done    <= n_done + 1;
        if (busy && cs_n)  n_glitch  <= n_glitch + 1;
        if (b_spi_start)   b_n_start <= b_n_start + 1;
        if (b_done)        b_n_done  <= b_n_done + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_a(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        while (!tx_ready && k < 200) begin @(negedge clk); k++; end
        if (!tx_ready) begin
            $display("FAIL push_a_wait: tx_ready=%0b required 1", tx_ready);
            compared++; mismatched++;
        end
        tx_data = b; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        while (!b_tx_ready && k < 200) begin @(negedge clk); k++; end
        if (!b_tx_ready) begin
            $display("FAIL push_b_wait: tx_ready=%0b required 1", b_tx_ready);
            compared++; mismatched++;
        end
        b_tx_data = b; b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
    endtask

    task automatic go_a(input logic [7:0] l);
        @(negedge clk);
        len = l; go = 1'b1;
        @(posedge clk); #1;
        go_cyc  = cyc;
        go_cs_n = cs_n;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic go_b(input logic [7:0] l);
        @(negedge clk);
        b_len = l; b_go = 1'b1;
        @(negedge clk);
        b_go = 1'b0;
    endtask

    task automatic wait_start_a(output int unsigned at);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk); #1;
            if (spi_start) seen = 1'b1;
        end
        at = cyc;
        if (!seen) begin
            $display("FAIL wait_start: spi_start=0 required 1 within 100 cycles");
            compared++; mismatched++;
        end
    endtask

    task automatic wait_done_a(output int unsigned at);
        bit seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        at = cyc;
        if (!seen) begin
            $display("FAIL wait_done: done_o=0 required 1 within 2000 cycles");
            compared++; mismatched++;
        end
    endtask

    task automatic wait_done_b();
        bit seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(posedge clk); #1;
            if (b_done) seen = 1'b1;
        end
        if (!seen) begin
            $display("FAIL wait_done_b: done_o=0 required 1 within 2000 cycles");
            compared++; mismatched++;
        end
    endtask

    task automatic pop_a(output logic [7:0] d, output logic v);
        @(negedge clk);
        d = rx_data; v = rx_valid; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pop_b(output logic [7:0] d, output logic v);
        @(negedge clk);
        d = b_rx_data; v = b_rx_valid; b_rx_ready = 1'b1;
        @(negedge clk);
        b_rx_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        compared += 8;
        if (cs_n !== 1'b1)      begin $display("FAIL reset_cs_n: got %0b want 1", cs_n); mismatched++; end
        if (busy !== 1'b0)      begin $display("FAIL reset_busy: got %0b want 0", busy); mismatched++; end
        if (done !== 1'b0)      begin $display("FAIL reset_done: got %0b want 0", done); mismatched++; end
        if (err !== 1'b0)       begin $display("FAIL reset_err: got %0b want 0", err); mismatched++; end
        if (spi_start !== 1'b0) begin $display("FAIL reset_start: got %0b want 0", spi_start); mismatched++; end
        if (spi_din !== 8'h00)  begin $display("FAIL reset_din: got %h want 00", spi_din); mismatched++; end
        if (tx_ready !== 1'b1)  begin $display("FAIL reset_tx_ready: got %0b want 1", tx_ready); mismatched++; end
        if (rx_valid !== 1'b0)  begin $display("FAIL reset_rx_valid: got %0b want 0", rx_valid); mismatched++; end
    endtask

    task automatic test_single();
        int unsigned t_start, t_tick, t_rise;
        bit seen;
        logic [7:0] d; logic v;
        push_a(8'hA5);
        go_a(8'd1);
        compared++;
        if (go_cs_n !== 1'b0) begin $display("FAIL single_cs_fall: cs_n=%0b want 0 one cycle after go", go_cs_n); mismatched++; end
        wait_start_a(t_start);
        compared += 2;
        if (t_start - go_cyc != 5) begin $display("FAIL single_start_lat: got %0d want 5", t_start - go_cyc); mismatched++; end
        if (spi_din !== 8'hA5)     begin $display("FAIL single_din: got %h want a5", spi_din); mismatched++; end
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin @(posedge clk); #1; if (done_tick) seen = 1'b1; end
        t_tick = cyc;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin @(posedge clk); #1; if (cs_n) seen = 1'b1; end
        t_rise = cyc;
        // tick is sampled one edge after it appears; cs_n rises 4 cycles after that sampling edge
        compared += 2;
        if (t_rise - t_tick != 5) begin $display("FAIL single_cs_rise: got %0d want 5", t_rise - t_tick); mismatched++; end
        if (done !== 1'b1)        begin $display("FAIL single_done_with_cs: got %0b want 1", done); mismatched++; end
        pop_a(d, v);
        compared += 2;
        if (v !== 1'b1)  begin $display("FAIL single_rx_valid: got %0b want 1", v); mismatched++; end
        if (d !== 8'h3C) begin $display("FAIL single_rx_data: got %h want 3c", d); mismatched++; end
    endtask

    task automatic test_burst4();
        int s0, d0, g0;
        int unsigned t;
        logic [7:0] d; logic v;
        logic [7:0] exp_rx [4] = '{8'h98, 8'h9B, 8'h9A, 8'h9D};
        s0 = n_start; d0 = n_done; g0 = n_glitch;
        for (int i = 1; i <= 4; i++) push_a(8'(i));
        go_a(8'd4);
        wait_done_a(t);
        repeat (5) @(posedge clk);
        #1;
        compared += 3;
        if (n_start - s0 != 4)  begin $display("FAIL burst_starts: got %0d want 4", n_start - s0); mismatched++; end
        if (n_done - d0 != 1)   begin $display("FAIL burst_dones: got %0d want 1", n_done - d0); mismatched++; end
        if (n_glitch - g0 != 0) begin $display("FAIL burst_cs_glitch: got %0d want 0", n_glitch - g0); mismatched++; end
        for (int i = 0; i < 4; i++) begin
            pop_a(d, v);
            compared++;
            if (v !== 1'b1 || d !== exp_rx[i]) begin
                $display("FAIL burst_rx%0d: got v=%0b %h want v=1 %h", i, v, d, exp_rx[i]); mismatched++;
            end
        end
    endtask

    task automatic test_starve();
        int s0;
        int unsigned t;
        logic [7:0] d; logic v;
        logic [7:0] exp_rx [3] = '{8'h88, 8'hBB, 8'hAA};
        s0 = n_start;
        push_a(8'h11);
        go_a(8'd3);
        repeat (20) @(posedge clk);
        #1;
        compared += 3;
        if (n_start - s0 != 1) begin $display("FAIL starve_starts: got %0d want 1", n_start - s0); mismatched++; end
        if (busy !== 1'b1)     begin $display("FAIL starve_busy: got %0b want 1", busy); mismatched++; end
        if (cs_n !== 1'b0)     begin $display("FAIL starve_cs_n: got %0b want 0", cs_n); mismatched++; end
        push_a(8'h22);
        push_a(8'h33);
        wait_done_a(t);
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (n_start - s0 != 3) begin $display("FAIL starve_total_starts: got %0d want 3", n_start - s0); mismatched++; end
        for (int i = 0; i < 3; i++) begin
            pop_a(d, v);
            compared++;
            if (v !== 1'b1 || d !== exp_rx[i]) begin
                $display("FAIL starve_rx%0d: got v=%0b %h want v=1 %h", i, v, d, exp_rx[i]); mismatched++;
            end
        end
    endtask

    task automatic test_len_zero();
        int s0, d0;
        s0 = n_start; d0 = n_done;
        go_a(8'd0);
        compared++;
        if (go_cs_n !== 1'b1) begin $display("FAIL len0_cs_n: got %0b want 1", go_cs_n); mismatched++; end
        repeat (8) @(posedge clk);
        #1;
        compared += 3;
        if (busy !== 1'b0)     begin $display("FAIL len0_busy: got %0b want 0", busy); mismatched++; end
        if (n_done - d0 != 0)  begin $display("FAIL len0_done: got %0d want 0", n_done - d0); mismatched++; end
        if (n_start - s0 != 0) begin $display("FAIL len0_start: got %0d want 0", n_start - s0); mismatched++; end
    endtask

    task automatic test_go_while_busy();
        int s0, d0;
        int unsigned t;
        logic [7:0] d; logic v;
        s0 = n_start; d0 = n_done;
        push_a(8'h44);
        go_a(8'd1);
        go_a(8'd2);
        wait_done_a(t);
        repeat (12) @(posedge clk);
        #1;
        compared += 4;
        if (n_start - s0 != 1) begin $display("FAIL busy_go_starts: got %0d want 1", n_start - s0); mismatched++; end
        if (n_done - d0 != 1)  begin $display("FAIL busy_go_dones: got %0d want 1", n_done - d0); mismatched++; end
        if (busy !== 1'b0)     begin $display("FAIL busy_go_idle: got %0b want 0", busy); mismatched++; end
        if (cs_n !== 1'b1)     begin $display("FAIL busy_go_cs_n: got %0b want 1", cs_n); mismatched++; end
        pop_a(d, v);
        compared++;
        if (v !== 1'b1 || d !== 8'hDD) begin $display("FAIL busy_go_rx: got v=%0b %h want v=1 dd", v, d); mismatched++; end
    endtask

    task automatic test_reset_mid();
        int unsigned t;
        for (int i = 0; i < 8; i++) push_a(8'h60 + 8'(i));
        go_a(8'd1);
        wait_start_a(t);
        push_a(8'h68);
        compared += 2;
        if (tx_ready !== 1'b0) begin $display("FAIL rstmid_tx_full: got %0b want 0", tx_ready); mismatched++; end
        if (cs_n !== 1'b0)     begin $display("FAIL rstmid_in_xfer_cs: got %0b want 0", cs_n); mismatched++; end
        rst_n = 1'b0;
        #1;
        compared += 4;
        if (cs_n !== 1'b1)      begin $display("FAIL rstmid_cs_n: got %0b want 1", cs_n); mismatched++; end
        if (tx_ready !== 1'b1)  begin $display("FAIL rstmid_tx_ready: got %0b want 1", tx_ready); mismatched++; end
        if (busy !== 1'b0)      begin $display("FAIL rstmid_busy: got %0b want 0", busy); mismatched++; end
        if (rx_valid !== 1'b0)  begin $display("FAIL rstmid_rx_valid: got %0b want 0", rx_valid); mismatched++; end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int s0, d0;
        logic [7:0] d; logic v;
        s0 = b_n_start; d0 = b_n_done;
        b_rx_ready = 1'b0;
        push_b(8'hA1);
        push_b(8'hA2);
        go_b(8'd4);
        push_b(8'hA3);
        push_b(8'hA4);
        repeat (40) @(posedge clk);
        #1;
        compared += 3;
        if (b_n_start - s0 != 2) begin $display("FAIL bp_stall_starts: got %0d want 2", b_n_start - s0); mismatched++; end
        if (b_busy !== 1'b1)     begin $display("FAIL bp_busy: got %0b want 1", b_busy); mismatched++; end
        if (b_cs_n !== 1'b0)     begin $display("FAIL bp_cs_n: got %0b want 0", b_cs_n); mismatched++; end
        pop_b(d, v);
        compared++;
        if (v !== 1'b1 || d !== 8'h38) begin $display("FAIL bp_rx0: got v=%0b %h want v=1 38", v, d); mismatched++; end
        pop_b(d, v);
        compared++;
        if (v !== 1'b1 || d !== 8'h3B) begin $display("FAIL bp_rx1: got v=%0b %h want v=1 3b", v, d); mismatched++; end
        wait_done_b();
        repeat (2) @(posedge clk);
        #1;
        compared += 2;
        if (b_n_start - s0 != 4) begin $display("FAIL bp_total_starts: got %0d want 4", b_n_start - s0); mismatched++; end
        if (b_n_done - d0 != 1)  begin $display("FAIL bp_dones: got %0d want 1", b_n_done - d0); mismatched++; end
        pop_b(d, v);
        compared++;
        if (v !== 1'b1 || d !== 8'h3A) begin $display("FAIL bp_rx2: got v=%0b %h want v=1 3a", v, d); mismatched++; end
        pop_b(d, v);
        compared++;
        if (v !== 1'b1 || d !== 8'h3D) begin $display("FAIL bp_rx3: got v=%0b %h want v=1 3d", v, d); mismatched++; end
    endtask

`ifdef SPI_XFER_TIMEOUT_EN
    task automatic test_timeout();
        int unsigned t_start, t_err, t_done;
        bit seen = 1'b0;
        eng_hang = 1'b1;
        push_a(8'h77);
        go_a(8'd1);
        compared++;
        if (err !== 1'b0) begin $display("FAIL to_err_cleared: got %0b want 0", err); mismatched++; end
        wait_start_a(t_start);
        for (int k = 0; k < 100 && !seen; k++) begin @(posedge clk); #1; if (err) seen = 1'b1; end
        t_err = cyc;
        compared++;
        if (!seen || t_err - t_start != 16) begin
            $display("FAIL to_err_lat: got %0d want 16 (seen=%0b)", t_err - t_start, seen); mismatched++;
        end
        wait_done_a(t_done);
        compared += 4;
        if (t_done - t_err != 4) begin $display("FAIL to_hold_len: got %0d want 4", t_done - t_err); mismatched++; end
        if (cs_n !== 1'b1)       begin $display("FAIL to_cs_n: got %0b want 1", cs_n); mismatched++; end
        if (rx_valid !== 1'b0)   begin $display("FAIL to_rx_discard: got %0b want 0", rx_valid); mismatched++; end
        if (err !== 1'b1)        begin $display("FAIL to_err_sticky: got %0b want 1", err); mismatched++; end
        @(negedge clk);
        rst_n = 1'b0;
        eng_hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`else
    task automatic test_err_tied();
        compared++;
        if (err !== 1'b0) begin $display("FAIL err_tied: got %0b want 0", err); mismatched++; end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        len = 8'h00; go = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; eng_hang = 1'b0;
        b_len = 8'h00; b_go = 1'b0; b_tx_data = 8'h00; b_tx_valid = 1'b0; b_rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_single();
        test_burst4();
        test_starve();
        test_len_zero();
        test_go_while_busy();
        test_backpressure();
`ifdef SPI_XFER_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
